lan_intn_pio: RTL
=================

// Module: lan_intn_pio
// PURPOSE
//  Avalon-MM slave input PIO that samples the LAN controller's status/interrupt pins (in_port).
//  It is the read-side counterpart of the LAN reset output PIO on the same Avalon bus.
//  Synchronises and debounces the pins, then captures edges into a sticky register and raises irq to the CPU.
// PARAMETERS
//  WIDTH      1   number of input pins (1..32)
//  DEBOUNCE   4   cycles a synced level must hold before being accepted; 0 = bypass filter
//  EDGE_TYPE  2   0 = rising, 1 = falling, 2 = any edge captured
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous active-low reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous pins from LAN device
//  readdata    out  32     read data, registered
//  irq         out  1      active-high interrupt, level
// BEHAVIOUR
//  Reset (async, reset_n=0): all flops cleared.
//   - sync stages, filtered, counters, edgecapture, irqmask, readdata = 0; irq = 0.
//  Sync: 2-FF synchroniser per bit. A pin change reaches sync2 after 2 clocks.
//  Debounce (DEBOUNCE>0), per bit:
//   - counter clears whenever sync2 == filtered.
//   - Otherwise it increments each clock.
//   - On reaching DEBOUNCE-1, filtered takes sync2 and the counter clears.
//   - A glitch shorter than DEBOUNCE cycles never changes filtered.
//   - Counter width is clog2(DEBOUNCE+1); it never wraps.
//  Debounce bypass (DEBOUNCE=0): filtered = sync2, registered once (1 clk).
//  Edge detect: compare filtered with its previous value filt_d.
//   - Rising = filtered & ~filt_d; falling = ~filtered & filt_d; selected by EDGE_TYPE.
//   - Because filtered resets to 0, a pin held high through reset yields one rising edge once accepted.
//  Register map (word address), write = chipselect & ~write_n:
//   - 0 DATA  RO: filtered[WIDTH-1:0]; writes ignored.
//   - 1 rsvd: reads 0, writes ignored.
//   - 2 MASK  RW: irqmask[WIDTH-1:0] <= writedata[WIDTH-1:0].
//   - 3 EDGE  R/W1C: reads edgecapture; a write clears the bits where writedata=1.
//  Edge capture set/clear:
//   - Bit sets on a detected edge and stays set until cleared.
//   - Same-cycle edge and W1C on a bit: set wins (the bit remains 1).
//  Read: readdata <= {zero-extend, mux(address)} every clock, so the value is valid 1 clk after the address is presented.
//   - Upper 32-WIDTH bits are always 0.
//   - Reads have no side effects.
//  irq = |(edgecapture & irqmask), from registers only, with no extra latency.
//   - irq falls the clock after the W1C or mask-clear write.
//  Total pin-to-irq latency = 2 (sync) + DEBOUNCE (filter; 1 clk if DEBOUNCE=0) + 1 (capture) clocks.
//  Reset mid-debounce or mid-capture: all state is discarded immediately, with no pending irq after release.
// TESTING
//  1. Reset: in_port=0, reset_n low 5 clks -> readdata=0 at all addresses, irq=0.
//  2. WIDTH=1, DEBOUNCE=4, EDGE_TYPE=0, MASK=1; in_port 0->1 held
//     -> DATA reads 1 and EDGE reads 1 with irq=1, exactly 7 clks after the change.
//  3. Glitch: in_port high for 3 clks then low (DEBOUNCE=4)
//     -> DATA stays 0, EDGE stays 0, irq stays 0.
//  4. W1C: EDGE=1, write 0x1 to addr 3 -> EDGE=0 and irq=0 next clk.
//     Repeat with an edge arriving in the same clk -> EDGE stays 1 and irq stays 1.
//  5. Mask: EDGE=1 with MASK=0 -> irq=0; write MASK=1 -> irq=1 next clk; EDGE unaffected by the mask.
//  6. EDGE_TYPE=2, pulse in_port 1 then 0 with EDGE cleared between
//     -> both edges captured; assert reset_n mid-debounce -> no capture after release.

Source files
------------

// File: rtl/lan_intn_pio.sv
// Avalon-MM input PIO for the LAN controller status/interrupt pins.
// The pins are synchronised and debounced, edges are captured into a sticky W1C register, and a level irq is raised.
module lan_intn_pio #(
    parameter int WIDTH     = 1,
    parameter int DEBOUNCE  = 4,
    parameter int EDGE_TYPE = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [1:0]       i_address,
    input  logic             i_chipselect,
    input  logic             i_write_n,
    input  logic [31:0]      i_writedata,
    input  logic [WIDTH-1:0] i_in_port,
    output logic [31:0]      o_readdata,
    output logic             o_irq
);

    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_d;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE > 0) begin : g_deb
            logic [CW-1:0] r_cnt [WIDTH];

            // A level is accepted only after it has disagreed with r_filt for DEBOUNCE clocks in a row.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_filt <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_sync2[i] == r_filt[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CW'(DEBOUNCE - 1)) begin
                            r_filt[i] <= r_sync2[i];
                            r_cnt[i]  <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end else begin : g_bypass
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_filt <= '0;
                end else begin
                    r_filt <= r_sync2;
                end
            end
        end
    endgenerate

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;
    assign w_det  = (EDGE_TYPE == 0) ? w_rise :
                    (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);

    assign w_wr  = i_chipselect & ~i_write_n;
    assign w_clr = (w_wr && (i_address == 2'd3)) ? i_writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (i_address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_filt;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
            default: w_rd_mux = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear, so it survives a same-cycle W1C.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_filt_d   <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_readdata <= '0;
        end else begin
            r_filt_d   <= r_filt;
            r_edge     <= (r_edge & ~w_clr) | w_det;
            r_readdata <= w_rd_mux;
            if (w_wr && (i_address == 2'd2)) begin
                r_mask <= i_writedata[WIDTH-1:0];
            end
        end
    end

    assign o_irq      = |(r_edge & r_mask);
    assign o_readdata = r_readdata;
    assign w_unused   = ^i_writedata;

endmodule
